fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_norm_round.sv | 75 +++++++
 rtl/fp_mult_pipe.sv | 158 +++++++++++++++
 tb/tb_fp_mult_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, operand classes and helpers for the small-float multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

    // Default field widths of the 13-bit {sign, exponent, fraction} format
    localparam int FP_NB_MANT  = 8;
    localparam int FP_NB_EXP   = 4;
    localparam int FP_NB_TOTAL = 1 + FP_NB_EXP + FP_NB_MANT;

    // Bit positions inside the 3-bit flags word {inv, ovf, unf}
    localparam int NB_FLAGS = 3;
    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    // Special-value encodings at the default width (sign of INF is patched per result)
    localparam logic [FP_NB_TOTAL-1:0] FP_INF = {1'b0, {FP_NB_EXP{1'b1}}, {FP_NB_MANT{1'b0}}};
    localparam logic [FP_NB_TOTAL-1:0] FP_NAN = {1'b0, {FP_NB_EXP{1'b1}}, {FP_NB_MANT{1'b1}}};

    // Class of the product, decided from the operands before any arithmetic
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_t;

    // Exponent bias for a given exponent field width
    function automatic int fp_bias(input int nb_exp);
        return (1 << (nb_exp - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Final stage: normalise the raw significand product, round to nearest even, pack.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline register holds its inputs when stalled.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int NB_MANT  = 8,
    parameter int NB_EXP   = 4,
    parameter int NB_TOTAL = 13
) (
    input  logic [2*NB_MANT+1:0]      prod,
    input  logic signed [NB_EXP+1:0]  exp_in,
    input  logic                      sign,
    input  logic [1:0]                cls,
    output logic [NB_TOTAL-1:0]       word,
    output logic [2:0]                flags
);

    localparam int PW = 2 * (NB_MANT + 1);
    localparam int EW = NB_EXP + 2;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << NB_EXP) - 1);

    logic [PW-2:0]          frac_bits;
    logic signed [EW-1:0]   e_norm;
    logic signed [EW-1:0]   e_fin;
    logic [NB_MANT-1:0]     mant;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [NB_MANT:0]       mant_rnd;

    // Normalise (drop hidden bit), round on guard+sticky, then range-check and handle special classes
    always_comb begin
        word  = '0;
        flags = '0;

        // Product lies in [1,4): if the top bit is set the point moves one place left
        frac_bits = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        e_norm    = exp_in + EW'(prod[PW-1]);

        mant     = frac_bits[PW-2 -: NB_MANT];
        guard    = frac_bits[PW-2-NB_MANT];
        sticky   = |frac_bits[PW-3-NB_MANT:0];
        round_up = guard & (sticky | mant[0]);

        // A carry out of the fraction means 1.11..1 rounded to 10.00..0: fraction is already zero
        mant_rnd = {1'b0, mant} + {{NB_MANT{1'b0}}, round_up};
        e_fin    = e_norm + EW'(mant_rnd[NB_MANT]);

        case (cls)
            CLS_NAN: begin
                word            = {1'b0, {NB_EXP{1'b1}}, {NB_MANT{1'b1}}};
                flags[FLAG_INV] = 1'b1;
            end
            CLS_INF: begin
                word = {sign, {NB_EXP{1'b1}}, {NB_MANT{1'b0}}};
            end
            CLS_ZERO: begin
                word = {sign, {(NB_TOTAL-1){1'b0}}};
            end
            default: begin
                if (e_fin >= E_MAX) begin
                    word            = {sign, {NB_EXP{1'b1}}, {NB_MANT{1'b0}}};
                    flags[FLAG_OVF] = 1'b1;
                end else if (e_fin[EW-1] || (e_fin == '0)) begin
                    word            = {sign, {(NB_TOTAL-1){1'b0}}};
                    flags[FLAG_UNF] = 1'b1;
                end else begin
                    word = {sign, e_fin[NB_EXP-1:0], mant_rnd[NB_MANT-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier: unpack/classify, significand multiply, normalise/round/pack.
// Latency: 3 cycles from accepted operands to out_valid; one result per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage holds while stalled.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int NB_MANT  = 8,
    parameter int NB_EXP   = 4,
    parameter int NB_TOTAL = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NB_TOTAL-1:0]  A,
    input  logic [NB_TOTAL-1:0]  B,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NB_TOTAL-1:0]  C,
    output logic [2:0]           flags,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int MW   = NB_MANT + 1;
    localparam int PW   = 2 * MW;
    localparam int EW   = NB_EXP + 2;
    localparam int BIAS = fp_bias(NB_EXP);

    // Word width must match the field layout; refuse to elaborate otherwise
    if (NB_TOTAL != 1 + NB_EXP + NB_MANT) begin : g_width_check
        $error("fp_mult_pipe: NB_TOTAL must equal 1+NB_EXP+NB_MANT");
    end

    // Operand fields
    logic                   sign_a, sign_b;
    logic [NB_EXP-1:0]      exp_a, exp_b;
    logic [NB_MANT-1:0]     frac_a, frac_b;
    logic                   a_zero, a_inf, a_nan;
    logic                   b_zero, b_inf, b_nan;
    logic signed [EW-1:0]   exp_sum;
    fp_cls_t                cls_in;

    // Stage 1 registers
    logic                   s1_vld;
    logic                   s1_sign;
    logic signed [EW-1:0]   s1_exp;
    fp_cls_t                s1_cls;
    logic [MW-1:0]          s1_ma, s1_mb;

    // Stage 2 registers
    logic                   s2_vld;
    logic                   s2_sign;
    logic signed [EW-1:0]   s2_exp;
    fp_cls_t                s2_cls;
    logic [PW-1:0]          s2_prod;

    // Stage 3 combinational result
    logic [NB_TOTAL-1:0]    s3_word;
    logic [2:0]             s3_flags;

    assign in_ready = !out_valid || out_ready;

    // Unpack operands, classify the product and form the unbiased exponent with headroom bits
    always_comb begin
        sign_a = A[NB_TOTAL-1];
        sign_b = B[NB_TOTAL-1];
        exp_a  = A[NB_TOTAL-2 -: NB_EXP];
        exp_b  = B[NB_TOTAL-2 -: NB_EXP];
        frac_a = A[NB_MANT-1:0];
        frac_b = B[NB_MANT-1:0];

        a_zero = (exp_a == '0);
        b_zero = (exp_b == '0);
        a_inf  = (&exp_a) && (frac_a == '0);
        b_inf  = (&exp_b) && (frac_b == '0);
        a_nan  = (&exp_a) && (frac_a != '0);
        b_nan  = (&exp_b) && (frac_b != '0);

        exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - EW'(BIAS);

        cls_in = CLS_NORM;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            cls_in = CLS_NAN;
        end else if (a_inf || b_inf) begin
            cls_in = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_in = CLS_ZERO;
        end
    end

    // Stage 1: capture sign, exponent sum, class and significands with hidden bit restored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_cls  <= CLS_ZERO;
            s1_ma   <= '0;
            s1_mb   <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_a ^ sign_b;
                s1_exp  <= exp_sum;
                s1_cls  <= cls_in;
                s1_ma   <= {1'b1, frac_a};
                s1_mb   <= {1'b1, frac_b};
            end
        end
    end

    // Stage 2: full-width significand product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_cls  <= CLS_ZERO;
            s2_prod <= '0;
        end else if (in_ready) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sign <= s1_sign;
                s2_exp  <= s1_exp;
                s2_cls  <= s1_cls;
                s2_prod <= PW'(s1_ma) * PW'(s1_mb);
            end
        end
    end

    fp_norm_round #(
        .NB_MANT  (NB_MANT),
        .NB_EXP   (NB_EXP),
        .NB_TOTAL (NB_TOTAL)
    ) u_norm_round (
        .prod   (s2_prod),
        .exp_in (s2_exp),
        .sign   (s2_sign),
        .cls    (s2_cls),
        .word   (s3_word),
        .flags  (s3_flags)
    );

    // Stage 3: register the packed result; a consumed or empty output slot takes the next entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            C         <= '0;
            flags     <= '0;
        end else if (in_ready) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                C     <= s3_word;
                flags <= s3_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed vectors, stall burst, random traffic, mid-flight reset.
// Latency: checks the 3-cycle acceptance-to-out_valid timing directly.
// Backpressure: drives out_ready patterns and checks in_ready while stalled.
module tb_fp_mult_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] A = '0;
    logic [12:0] B = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] C;
    logic [2:0]  flags;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_acc   = 0;

    typedef struct packed {
        logic [31:0] id;
        logic [2:0]  f;
        logic [12:0] c;
    } exp_t;

    exp_t scb[$];

    fp_mult_pipe #(.NB_MANT(8), .NB_EXP(4), .NB_TOTAL(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounding by remainder comparison; returns {flags, C}
    function automatic logic [15:0] model(input logic [12:0] a, input logic [12:0] b);
        int ea, eb, fa, fb, p, e, s, q, r, half;
        bit an, ai, az, bn, bi, bz;
        logic sg;
        logic [15:0] res;
        ea = int'(a[11:8]); eb = int'(b[11:8]);
        fa = int'(a[7:0]);  fb = int'(b[7:0]);
        sg = a[12] ^ b[12];
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 15) && (fa == 0); bi = (eb == 15) && (fb == 0);
        an = (ea == 15) && (fa != 0); bn = (eb == 15) && (fb != 0);
        if (an || bn || (ai && bz) || (bi && az)) begin
            res = {3'b100, FP_NAN};
        end else if (ai || bi) begin
            res = {3'b000, sg, 4'hF, 8'h00};
        end else if (az || bz) begin
            res = {3'b000, sg, 12'h000};
        end else begin
            p = (256 + fa) * (256 + fb);
            e = ea + eb - 7;
            s = 8;
            if (p >= (1 << 17)) begin
                s = 9;
                e = e + 1;
            end
            q = p >> s;
            r = p - (q << s);
            half = 1 << (s - 1);
            if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
            if (q == 512) begin
                q = 256;
                e = e + 1;
            end
            if (e >= 15)     res = {3'b010, sg, 4'hF, 8'h00};
            else if (e <= 0) res = {3'b001, sg, 12'h000};
            else             res = {3'b000, sg, e[3:0], q[7:0]};
        end
        return res;
    endfunction

    // Record transfers that the coming posedge will perform; score results in order
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] m;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                m = model(A, B);
                scb.push_back({n_acc, m[15:13], m[12:0]});
                n_acc++;
            end
            if (out_valid && !out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                check("result_expected", {31'd0, scb.size() != 0}, 32'd1);
                if (scb.size() != 0) begin
                    e = scb.pop_front();
                    check($sformatf("C[%0d]", e.id), {19'd0, C}, {19'd0, e.c});
                    check($sformatf("flags[%0d]", e.id), {29'd0, flags}, {29'd0, e.f});
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [12:0] a, input logic [12:0] b);
        bit acc;
        acc = 1'b0;
        A = a;
        B = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (scb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", scb.size(), 32'd0);
    endtask

    logic [12:0] vec_a [10] = '{13'h1800, 13'h0701, 13'h0EFF, 13'h0100, 13'h0F00,
                                13'h0F00, 13'h076A, 13'h0780, 13'h0780, 13'h0F01};
    logic [12:0] vec_b [10] = '{13'h0780, 13'h0701, 13'h0EFF, 13'h0100, 13'h0000,
                                13'h1780, 13'h076A, 13'h0701, 13'h0703, 13'h0780};

    initial begin
        int base;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_C", {19'd0, C}, 32'd0);
        check("rst_flags", {29'd0, flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 * 1.5 with latency check (send returns just after the accepting edge)
        send(13'h0780, 13'h0780);
        @(posedge clk);
        #1;
        check("lat_cycle2_idle", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle3_valid", {31'd0, out_valid}, 32'd1);
        check("lat_C", {19'd0, C}, 32'h0820);
        check("lat_flags", {29'd0, flags}, 32'd0);
        drain();

        // Directed vectors back-to-back, absolute values from hand calculation
        for (int i = 0; i < 10; i++) send(vec_a[i], vec_b[i]);
        drain();
        check("known_neg3", {16'd0, model(13'h1800, 13'h0780)}, 32'h1880);
        check("known_ovf", {16'd0, model(13'h0EFF, 13'h0EFF)}, 32'h4F00);
        check("known_inv", {16'd0, model(13'h0F00, 13'h0000)}, 32'h8FFF);

        // Ten back-to-back operands with out_ready low for cycles 4-7
        base = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(13'(13'h0700 + i * 13'h0011), 13'(13'h0680 + i * 13'h0023));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("burst_stall_valid", {31'd0, out_valid}, 32'd1);
                check("burst_stall_ready", {31'd0, in_ready}, 32'd0);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("burst_count", n_out - base, 32'd10);

        // Random operands with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)));
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operands in flight
        send(13'h0780, 13'h0780);
        send(13'h0800, 13'h0800);
        send(13'h0900, 13'h0780);
        rst_n = 1'b0;
        scb.delete();
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_C", {19'd0, C}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        send(13'h0880, 13'h0780);
        drain();
        check("post_rst_count", n_out - base, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete (tests %0d, failed %0d)", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
